// File: rtl/wb_grf_if.sv
// Bundles the MEM/WB inputs, the decode-stage read ports and the exported
// write-back signals that connect the pipeline to the write-back stage and register file.
interface wb_grf_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       Instr_WB;
  logic [31:0]       Pc4_WB;
  logic [DATA_W-1:0] ALUout_WB;
  logic [DATA_W-1:0] DM_Data_WB;
  logic [4:0]        A1_D;
  logic [4:0]        A2_D;
  logic [DATA_W-1:0] RD1_D;
  logic [DATA_W-1:0] RD2_D;
  logic              WB_we;
  logic [4:0]        WB_addr;
  logic [DATA_W-1:0] WB_data;

  modport master (
    output Instr_WB, Pc4_WB, ALUout_WB, DM_Data_WB, A1_D, A2_D,
    input  RD1_D, RD2_D, WB_we, WB_addr, WB_data
  );

  modport slave (
    input  Instr_WB, Pc4_WB, ALUout_WB, DM_Data_WB, A1_D, A2_D,
    output RD1_D, RD2_D, WB_we, WB_addr, WB_data
  );
endinterface

// File: rtl/wb_grf.sv
// MIPS write-back stage and 32-entry register file with WB->D read bypass.
// Define GRF_WRITE_TRACE_EN to print every committed register write in simulation.
module wb_grf #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic     clk,
  input logic     reset,
  wb_grf_if.slave bus
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic              isWrite;
  logic [4:0]        dest;
  logic [DATA_W-1:0] destData;
  logic              wrEn_d;
  logic [4:0]        wrAddr_d;
  logic [DATA_W-1:0] wrData_d;
  logic [DATA_W-1:0] grf_q [32];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              unusedInstrBits;

  assign op              = bus.Instr_WB[31:26];
  assign funct           = bus.Instr_WB[5:0];
  assign rt              = bus.Instr_WB[20:16];
  assign rd              = bus.Instr_WB[15:11];
  assign unusedInstrBits = ^{bus.Instr_WB[25:21], bus.Instr_WB[10:6]};

  // Classify the WB instruction into its destination register and write source.
  always_comb begin
    isWrite  = 1'b0;
    dest     = 5'd0;
    destData = '0;
    case (op)
      6'h00: begin
        if (funct == 6'h21 || funct == 6'h23) begin
          isWrite  = 1'b1;
          dest     = rd;
          destData = bus.ALUout_WB;
        end
      end
      6'h0d, 6'h0f: begin
        isWrite  = 1'b1;
        dest     = rt;
        destData = bus.ALUout_WB;
      end
      6'h23: begin
        isWrite  = 1'b1;
        dest     = rt;
        destData = bus.DM_Data_WB;
      end
      6'h03: begin
        isWrite  = 1'b1;
        dest     = 5'd31;
        destData = DATA_W'(bus.Pc4_WB + 32'd4);
      end
      default: begin
        isWrite  = 1'b0;
      end
    endcase
  end

  // A write to $0 is squashed so the forwarding unit never sees it as a producer.
  always_comb begin
    wrEn_d   = isWrite && (dest != 5'd0);
    wrAddr_d = wrEn_d ? dest : 5'd0;
    wrData_d = wrEn_d ? destData : '0;
  end

  assign bus.WB_we   = wrEn_d;
  assign bus.WB_addr = wrAddr_d;
  assign bus.WB_data = wrData_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= RESET_VAL;
      end
    end else if (wrEn_d) begin
      grf_q[wrAddr_d] <= wrData_d;
    end
  end

  // Bypass is suppressed during reset so the read ports show the cleared file.
  always_comb begin
    rd1 = grf_q[bus.A1_D];
    if (bus.A1_D == 5'd0) begin
      rd1 = '0;
    end else if (!reset && wrEn_d && wrAddr_d == bus.A1_D) begin
      rd1 = wrData_d;
    end
  end

  always_comb begin
    rd2 = grf_q[bus.A2_D];
    if (bus.A2_D == 5'd0) begin
      rd2 = '0;
    end else if (!reset && wrEn_d && wrAddr_d == bus.A2_D) begin
      rd2 = wrData_d;
    end
  end

  assign bus.RD1_D = rd1;
  assign bus.RD2_D = rd2;

`ifdef GRF_WRITE_TRACE_EN
  always @(posedge clk) begin
    if (!reset && wrEn_d) begin
      $display("@%h: $%d <= %h", bus.Pc4_WB - 32'd4, wrAddr_d, wrData_d);
    end
  end
`endif

endmodule
